// File: rtl/rv_mem_arbiter_if.sv
// Bus bundle for rv_mem_arbiter: three requester ports, the downstream RV memory
// port, and the grant/err status lines.
interface rv_mem_arbiter_if;
  localparam int unsigned AW = 23;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  logic          m0_valid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic [SW-1:0] m0_wstrb;
  logic          m0_ready;
  logic [DW-1:0] m0_rdata;

  logic          m1_valid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [SW-1:0] m1_wstrb;
  logic          m1_ready;
  logic [DW-1:0] m1_rdata;

  logic          m2_valid;
  logic [AW-1:0] m2_addr;
  logic [DW-1:0] m2_wdata;
  logic [SW-1:0] m2_wstrb;
  logic          m2_ready;
  logic [DW-1:0] m2_rdata;

  logic          rv_valid;
  logic [AW-1:0] rv_addr;
  logic [DW-1:0] rv_wdata;
  logic [SW-1:0] rv_wstrb;
  logic          rv_ready;
  logic [DW-1:0] rv_rdata;

  logic [2:0]    grant;
  logic          err;

  // Arbiter side
  modport slave (
    input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
    input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
    input  m2_valid, m2_addr, m2_wdata, m2_wstrb,
    output m0_ready, m0_rdata, m1_ready, m1_rdata, m2_ready, m2_rdata,
    output rv_valid, rv_addr, rv_wdata, rv_wstrb,
    input  rv_ready, rv_rdata,
    output grant, err
  );

  // Requesters plus downstream memory controller side
  modport master (
    output m0_valid, m0_addr, m0_wdata, m0_wstrb,
    output m1_valid, m1_addr, m1_wdata, m1_wstrb,
    output m2_valid, m2_addr, m2_wdata, m2_wstrb,
    input  m0_ready, m0_rdata, m1_ready, m1_rdata, m2_ready, m2_rdata,
    input  rv_valid, rv_addr, rv_wdata, rv_wstrb,
    output rv_ready, rv_rdata,
    input  grant, err
  );
endinterface

// File: rtl/rv_mem_arbiter.sv
// Three-requester arbiter (m0 > m1 > m2 with starvation promotion of m1/m2) in front
// of the RV memory port. Optional BUSY watchdog enabled by macro ARB_TIMEOUT_EN.
module rv_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 64,
  parameter int unsigned TIMEOUT      = 4096
) (
  input logic             clk,
  input logic             resetn,
  rv_mem_arbiter_if.slave bus
);
  localparam int unsigned AW = 23;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned NM = 3;
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [DW-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [NM-1:0] grant_q;
  logic          rv_valid_q;
  logic [AW-1:0] rv_addr_q;
  logic [DW-1:0] rv_wdata_q;
  logic [SW-1:0] rv_wstrb_q;
  logic [CW-1:0] m1_cnt_q, m1_cnt_d;
  logic [CW-1:0] m2_cnt_q, m2_cnt_d;

  logic [NM-1:0] valid_c;
  logic [NM-1:0] win_c;
  logic          starve1_c, starve2_c;
  logic          arb_c;
  logic          complete_c;
  logic          timeout_c;
  logic [AW-1:0] sel_addr_c;
  logic [DW-1:0] sel_wdata_c;
  logic [SW-1:0] sel_wstrb_c;
  logic [NM-1:0] ready_c;
  logic [DW-1:0] rdata_c;

  assign valid_c    = {bus.m2_valid, bus.m1_valid, bus.m0_valid};
  assign starve1_c  = bus.m1_valid && (m1_cnt_q == CW'(STARVE_LIMIT));
  assign starve2_c  = bus.m2_valid && (m2_cnt_q == CW'(STARVE_LIMIT));
  assign arb_c      = (state_q == IDLE) && (|valid_c);
  assign complete_c = (state_q == BUSY) && (bus.rv_ready || timeout_c);

  // Winner: starved m1, starved m2, then fixed priority m0 > m1 > m2
  always_comb begin
    win_c = '0;
    if (starve1_c)       win_c = 3'b010;
    else if (starve2_c)  win_c = 3'b100;
    else if (valid_c[0]) win_c = 3'b001;
    else if (valid_c[1]) win_c = 3'b010;
    else if (valid_c[2]) win_c = 3'b100;
  end

  always_comb begin
    sel_addr_c  = bus.m0_addr;
    sel_wdata_c = bus.m0_wdata;
    sel_wstrb_c = bus.m0_wstrb;
    if (win_c[1]) begin
      sel_addr_c  = bus.m1_addr;
      sel_wdata_c = bus.m1_wdata;
      sel_wstrb_c = bus.m1_wstrb;
    end else if (win_c[2]) begin
      sel_addr_c  = bus.m2_addr;
      sel_wdata_c = bus.m2_wdata;
      sel_wstrb_c = bus.m2_wstrb;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|valid_c) state_d = BUSY;
      BUSY:    if (complete_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: completion pulse goes only to the current owner
  always_comb begin
    ready_c = '0;
    rdata_c = bus.rv_rdata;
    if (complete_c) ready_c = grant_q;
    if (timeout_c)  rdata_c = TIMEOUT_RDATA;
  end

  // Downstream request registers, held constant through BUSY
  always_ff @(posedge clk) begin
    if (!resetn) begin
      grant_q    <= '0;
      rv_valid_q <= 1'b0;
      rv_addr_q  <= '0;
      rv_wdata_q <= '0;
      rv_wstrb_q <= '0;
    end else if (arb_c) begin
      grant_q    <= win_c;
      rv_valid_q <= 1'b1;
      rv_addr_q  <= sel_addr_c;
      rv_wdata_q <= sel_wdata_c;
      rv_wstrb_q <= sel_wstrb_c;
    end else if (complete_c) begin
      grant_q    <= '0;
      rv_valid_q <= 1'b0;
    end
  end

  // Wait counters: clear when idle-valid or granted, else count up and saturate
  function automatic logic [CW-1:0] starve_next(input logic v, input logic g,
                                                input logic [CW-1:0] c);
    if (!v || g)                 return '0;
    if (c == CW'(STARVE_LIMIT))  return c;
    return c + CW'(1);
  endfunction

  assign m1_cnt_d = starve_next(bus.m1_valid, grant_q[1] | (arb_c & win_c[1]), m1_cnt_q);
  assign m2_cnt_d = starve_next(bus.m2_valid, grant_q[2] | (arb_c & win_c[2]), m2_cnt_q);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      m1_cnt_q <= '0;
      m2_cnt_q <= '0;
    end else begin
      m1_cnt_q <= m1_cnt_d;
      m2_cnt_q <= m2_cnt_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wd_q, wd_d;
  logic          err_q, err_d;

  // Watchdog counts BUSY cycles; fires on the TIMEOUT-th one if rv_ready is absent
  assign timeout_c = (state_q == BUSY) && !bus.rv_ready && (wd_q == TW'(TIMEOUT - 1));
  assign wd_d      = (state_q == BUSY) ? wd_q + TW'(1) : '0;
  assign err_d     = err_q | timeout_c;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^32'(TIMEOUT);
  assign timeout_c      = 1'b0;
  assign bus.err        = 1'b0;
`endif

  assign bus.grant    = grant_q;
  assign bus.rv_valid = rv_valid_q;
  assign bus.rv_addr  = rv_addr_q;
  assign bus.rv_wdata = rv_wdata_q;
  assign bus.rv_wstrb = rv_wstrb_q;
  assign bus.m0_ready = ready_c[0];
  assign bus.m1_ready = ready_c[1];
  assign bus.m2_ready = ready_c[2];
  assign bus.m0_rdata = rdata_c;
  assign bus.m1_rdata = rdata_c;
  assign bus.m2_rdata = rdata_c;
endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
- Three-requester arbiter in front of the 32-bit RV memory port (0x00_0000–0x7F_FFFF).
- Requesters:
  - m0: firmware/flash loader (highest priority).
  - m1: picorv32 softcore.
  - m2: savestate/DMA engine (lowest priority).
- Serialises single-beat valid/ready transactions onto one downstream port.
- Registers the granted request and enforces an anti-starvation rule.
- Replaces the hard-wired flash_loading mux in the IO subsystem.

Parameters:
- STARVE_LIMIT, 64: cycles a pending m1/m2 request may wait before it is promoted above higher-priority requesters.
- TIMEOUT, 4096: cycles without rv_ready before a transaction is aborted. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (SNES mclk domain)
- resetn  in  1  synchronous, active-low reset
- mN_valid  in  1  request from master N (N=0,1,2); held high until mN_ready
- mN_addr  in  23  byte address, stable while mN_valid
- mN_wdata  in  32  write data, stable while mN_valid
- mN_wstrb  in  4  byte strobes; 0 = read
- mN_ready  out  1  one-cycle completion pulse to master N
- mN_rdata  out  32  read data, valid in the mN_ready cycle
- rv_valid  out  1  downstream request, held until rv_ready
- rv_addr  out  23  registered address
- rv_wdata  out  32  registered write data
- rv_wstrb  out  4  registered strobes
- rv_ready  in  1  downstream one-cycle completion pulse
- rv_rdata  in  32  downstream read data, valid with rv_ready
- grant  out  3  one-hot current owner; 0 when idle
- err  out  1  sticky timeout flag (ARB_TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset values:
  - State IDLE; grant=0; rv_valid=0; rv_addr/rv_wdata/rv_wstrb=0.
  - All mN_ready=0; starvation counters=0; err=0.
- State machine: IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - If any mN_valid, select a winner.
  - Capture its addr/wdata/wstrb into the rv_* registers; set grant one-hot and rv_valid=1 on the next edge; go to BUSY.
  - Latency: 1 cycle from mN_valid to rv_valid.
- Winner selection:
  - A starved requester (counter == STARVE_LIMIT) wins first; if m1 and m2 are both starved, m1 wins.
  - Otherwise fixed priority: m0 > m1 > m2.
- BUSY:
  - rv_* registers are held constant.
  - When rv_ready=1: mN_ready = rv_ready & grant[N] (combinational, same cycle); mN_rdata = rv_rdata for the granted master.
  - On that edge: rv_valid<=0, grant<=0, go to DONE.
- DONE:
  - Fixed one-cycle bubble so the completed master can drop its valid.
  - No arbitration in this cycle; go to IDLE.
  - Back-to-back throughput: one transaction per (downstream latency + 3) cycles.
- mN_rdata:
  - Driven with rv_rdata for all N at all times; only meaningful with mN_ready.
- Starvation counters (m1, m2):
  - Increment each cycle the master's valid is high and it is not granted.
  - Saturate at STARVE_LIMIT.
  - Clear when the master is granted or its valid is low.
- Error cases:
  - rv_ready while IDLE or DONE: ignored; no mN_ready is generated.
  - mN_valid dropping mid-BUSY (protocol violation): the transaction still completes downstream and the ready pulse is still issued.
- Reset mid-BUSY:
  - Everything returns to reset values at that edge.
  - rv_valid drops without waiting for rv_ready; the downstream controller shares the reset.
- Simultaneous requests in IDLE: exactly one grant per arbitration; the others keep waiting and their counters increment.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A watchdog counts BUSY cycles.
  - On reaching TIMEOUT without rv_ready: pulse mN_ready to the owner with mN_rdata=32'hDEAD_BEEF, set err=1 (sticky until reset), drop rv_valid, go to DONE.
  - A late rv_ready arriving afterwards is ignored.
- When undefined: no watchdog, BUSY waits indefinitely, err tied 0.

Test Plan:
- Reset release, m1 read addr 0x000100, rv_ready after 3 cycles with rdata 0x12345678 -> rv_valid 1 cycle after m1_valid; rv_addr=0x000100, rv_wstrb=0; m1_ready pulse with m1_rdata=0x12345678; grant returns to 0.
- m0 and m1 valid in the same cycle -> grant=3'b001 first; m1 granted after the DONE bubble; m1 counter shows 1+ wait cycles.
- m0 issues continuous back-to-back writes while m2 is pending, STARVE_LIMIT=64 -> m2 granted once its counter reaches 64, before m0's next request; m2 counter then clears.
- m2 write wdata=0xAABBCCDD wstrb=4'b0100 -> rv_wdata/rv_wstrb match and stay stable through BUSY while m2 inputs are changed illegally.
- resetn low for one cycle mid-BUSY -> rv_valid=0, grant=0, no mN_ready pulse; a new m1 request afterwards completes normally.
- ARB_TIMEOUT_EN defined, TIMEOUT=16, rv_ready never asserted -> owner receives ready with 0xDEADBEEF at cycle 16; err=1 and stays 1; a late rv_ready produces no pulse.
